// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state type, init encodings and init-value helper for regfile_sb
package regfile_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } rf_state_e;

   localparam int INIT_ZERO  = 0;
   localparam int INIT_INDEX = 1;

   function automatic int unsigned init_val(input int unsigned idx, input int mode);
      return (mode == INIT_INDEX) ? idx : 32'd0;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for loads in flight
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREG    = 32,
   parameter bit ZERO_R0 = 1'b1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            set_en_i,
   input  logic [AW-1:0]   set_addr_i,
   input  logic            clr_en_i,
   input  logic [AW-1:0]   clr_addr_i,
   output logic [NREG-1:0] busy_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Set is applied after clear; the top never offers both on one register.
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
      if (ZERO_R0)  busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with bypass, init sweep and load busy scoreboard
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int NRD       = 2,
   parameter bit ZERO_R0   = 1'b1,
   parameter int INIT_MODE = INIT_ZERO,
   localparam int AW       = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                init_done,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                alloc_en,
   input  logic [AW-1:0]       alloc_addr,
   output logic                alloc_ok,
   input  logic                fill_en,
   input  logic [AW-1:0]       fill_addr,
   input  logic [XLEN-1:0]     fill_data
);

   rf_state_e       state_q;
   logic [AW-1:0]   cnt_q;
   logic            init_done_q;
   logic [XLEN-1:0] mem_q [NREG];
   logic [NREG-1:0] busy;
   logic            run;
   logic            wr_ok;
   logic            fill_ok;

   assign run     = (state_q == ST_RUN);
   assign wr_ok   = run & wr_en & !(ZERO_R0 && (wr_addr == '0));
   assign fill_ok = run & fill_en & !(ZERO_R0 && (fill_addr == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else if (state_q == ST_INIT) begin
         cnt_q <= cnt_q + AW'(1);
         if (cnt_q == AW'(NREG - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
         end
      end
   end

   // Writeback is issued after the fill so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_INIT) begin
            mem_q[cnt_q] <= XLEN'(init_val(32'(cnt_q), INIT_MODE));
         end else begin
            if (fill_ok) mem_q[fill_addr] <= fill_data;
            if (wr_ok)   mem_q[wr_addr]   <= wr_data;
         end
      end
   end

   regfile_scoreboard #(
      .NREG    (NREG),
      .ZERO_R0 (ZERO_R0)
   ) u_sb (
      .clk_i      (clk),
      .rst_i      (rst),
      .set_en_i   (alloc_en & alloc_ok),
      .set_addr_i (alloc_addr),
      .clr_en_i   (run & fill_en),
      .clr_addr_i (fill_addr),
      .busy_o     (busy)
   );

   assign init_done = init_done_q;
   assign alloc_ok  = init_done_q & ~busy[alloc_addr];

   always_comb begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rv;
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rv      = '0;
      for (int k = 0; k < NRD; k++) begin
         ra = rd_addr[k*AW +: AW];
         if (ZERO_R0 && (ra == '0))              rv = '0;
         else if (run && wr_en && wr_addr == ra)     rv = wr_data;
         else if (run && fill_en && fill_addr == ra) rv = fill_data;
         else                                        rv = mem_q[ra];
         rd_data[k*XLEN +: XLEN] = rv;
         rd_busy[k] = busy[ra] & ~(run & fill_en & (fill_addr == ra));
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb with directed vectors
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

   localparam int S_RD0   = 0;
   localparam int S_RD1   = 1;
   localparam int S_BUSY0 = 2;
   localparam int S_BUSY1 = 3;
   localparam int S_AOK   = 4;
   localparam int S_IDONE = 5;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                init_done;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                alloc_en;
   logic [AW-1:0]       alloc_addr;
   logic                alloc_ok;
   logic                fill_en;
   logic [AW-1:0]       fill_addr;
   logic [XLEN-1:0]     fill_data;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   regfile_sb #(
      .XLEN      (XLEN),
      .NREG      (NREG),
      .NRD       (NRD),
      .ZERO_R0   (1'b1),
      .INIT_MODE (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .init_done  (init_done),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .alloc_ok   (alloc_ok),
      .fill_en    (fill_en),
      .fill_addr  (fill_addr),
      .fill_data  (fill_data)
   );

   always #5 clk = ~clk;

   // Monitor: drains every expectation queued since the last edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e = exp_q.pop_front();
         case (e.sig)
            S_RD0:   act = rd_data[31:0];
            S_RD1:   act = rd_data[63:32];
            S_BUSY0: act = {31'd0, rd_busy[0]};
            S_BUSY1: act = {31'd0, rd_busy[1]};
            S_AOK:   act = {31'd0, alloc_ok};
            default: act = {31'd0, init_done};
         endcase
         n_vec++;
         if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
         end
      end
   end

   task automatic expect_sig(input string name, input int sig, input logic [31:0] v);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.exp  = v;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      alloc_en = 1'b0;
      fill_en  = 1'b0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle();
      wr_addr = '0; wr_data = '0; alloc_addr = '0; fill_addr = '0; fill_data = '0;
      set_rd(5'd7, 5'd0);
      step();
      expect_sig("reset_init_done", S_IDONE, 0);
      expect_sig("reset_alloc_ok", S_AOK, 0);
      expect_sig("reset_busy0", S_BUSY0, 0);
      expect_sig("reset_busy1", S_BUSY1, 0);

      // Init sweep with writes/allocs to reg 7 that must be ignored
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hBAD0BAD0;
      alloc_en = 1'b1; alloc_addr = 5'd7;
      for (int i = 1; i <= NREG; i++) begin
         step();
         if (i == NREG) idle();
         expect_sig("sweep_init_done", S_IDONE, (i == NREG) ? 32'd1 : 32'd0);
         expect_sig("sweep_alloc_ok", S_AOK, (i == NREG) ? 32'd1 : 32'd0);
         if (i >= 8) expect_sig("sweep_rd7", S_RD0, 32'd7);
      end
      expect_sig("post_init_busy7", S_BUSY0, 0);
      expect_sig("post_init_r0", S_RD1, 0);

      // Bypass on both ports
      step();
      set_rd(5'd5, 5'd5);
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      expect_sig("bypass_p0", S_RD0, 32'hDEADBEEF);
      expect_sig("bypass_p1", S_RD1, 32'hDEADBEEF);
      step();
      idle();
      expect_sig("stored_p0", S_RD0, 32'hDEADBEEF);
      expect_sig("stored_p1", S_RD1, 32'hDEADBEEF);

      // r0 ignores writes and allocations
      step();
      set_rd(5'd0, 5'd0);
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      alloc_en = 1'b1; alloc_addr = 5'd0;
      expect_sig("r0_rd_bypass", S_RD0, 0);
      expect_sig("r0_busy", S_BUSY0, 0);
      expect_sig("r0_alloc_ok", S_AOK, 1);
      step();
      idle();
      expect_sig("r0_rd_after", S_RD0, 0);
      expect_sig("r0_busy_after", S_BUSY0, 0);
      expect_sig("r0_alloc_ok_after", S_AOK, 1);

      // Scoreboard alloc / re-alloc / fill on reg 9
      step();
      set_rd(5'd9, 5'd0);
      alloc_en = 1'b1; alloc_addr = 5'd9;
      expect_sig("sb_alloc_ok", S_AOK, 1);
      expect_sig("sb_busy_before", S_BUSY0, 0);
      step();
      expect_sig("sb_busy_set", S_BUSY0, 1);
      expect_sig("sb_realloc_ok", S_AOK, 0);
      step();
      alloc_en = 1'b0;
      fill_en = 1'b1; fill_addr = 5'd9; fill_data = 32'hCAFE0000;
      expect_sig("sb_fill_busy", S_BUSY0, 0);
      expect_sig("sb_fill_rd", S_RD0, 32'hCAFE0000);
      expect_sig("sb_fill_aok", S_AOK, 0);
      step();
      idle();
      expect_sig("sb_after_busy", S_BUSY0, 0);
      expect_sig("sb_after_rd", S_RD0, 32'hCAFE0000);
      expect_sig("sb_after_aok", S_AOK, 1);

      // Write/fill collision on busy reg 12
      step();
      set_rd(5'd12, 5'd0);
      alloc_en = 1'b1; alloc_addr = 5'd12;
      step();
      idle();
      expect_sig("col_busy", S_BUSY0, 1);
      step();
      wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h11;
      fill_en = 1'b1; fill_addr = 5'd12; fill_data = 32'h22;
      expect_sig("col_rd", S_RD0, 32'h11);
      expect_sig("col_busy_fill", S_BUSY0, 0);
      step();
      idle();
      expect_sig("col_stored", S_RD0, 32'h11);
      expect_sig("col_busy_clr", S_BUSY0, 0);
      expect_sig("col_aok", S_AOK, 1);

      // Writeback to a busy register keeps it busy
      step();
      set_rd(5'd20, 5'd0);
      alloc_en = 1'b1; alloc_addr = 5'd20;
      step();
      idle();
      wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h55;
      step();
      idle();
      expect_sig("wrbusy_rd", S_RD0, 32'h55);
      expect_sig("wrbusy_busy", S_BUSY0, 1);

      // Reset mid-operation with regs 3 and 4 busy
      step();
      set_rd(5'd3, 5'd4);
      alloc_en = 1'b1; alloc_addr = 5'd3;
      step();
      alloc_addr = 5'd4;
      step();
      idle();
      expect_sig("mid_busy3", S_BUSY0, 1);
      expect_sig("mid_busy4", S_BUSY1, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      fill_en = 1'b1; fill_addr = 5'd3; fill_data = 32'h77;
      expect_sig("mid_rst_busy3", S_BUSY0, 0);
      expect_sig("mid_rst_busy4", S_BUSY1, 0);
      expect_sig("mid_rst_done", S_IDONE, 0);
      expect_sig("mid_rst_aok", S_AOK, 0);
      for (int i = 1; i <= NREG; i++) begin
         step();
         if (i == NREG) idle();
         expect_sig("resweep_init_done", S_IDONE, (i == NREG) ? 32'd1 : 32'd0);
         if (i >= 4) expect_sig("resweep_rd3", S_RD0, 32'd3);
         if (i >= 5) expect_sig("resweep_rd4", S_RD1, 32'd4);
      end
      expect_sig("resweep_busy3", S_BUSY0, 0);

      step();
      expect_sig("final_rd3", S_RD0, 32'd3);
      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
